fetch_stage: RTL and testbench

Instruction-fetch front end that sits directly upstream of the stream buffer. It holds the PC and issues one word-aligned demand fetch at a time over the stream buffer request/response handshake. Returned instructions go into an internal instruction queue (IQ) that feeds decode. On a control-flow redirect it discards stale in-flight responses and pulses the stream buffer invalidate.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_iq.sv | 44 ++++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   iq_entry_t    - one instruction-queue entry {pc, inst}
//   fetch_state_t - request tracking state {IDLE, WAIT, DROP}
//   RESET_PC_DEFAULT - default fetch address after reset
package fetch_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;
   typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
endpackage

// File: rtl/fetch_iq.sv
// fetch_iq: circular instruction queue of iq_entry_t.
//   clk, rst      - clock, asynchronous active-high reset
//   enq, enq_data - push an entry (ignored when full or flushing)
//   deq           - pop the head (ignored when empty or flushing)
//   flush         - empty the queue at the next edge
//   head          - head entry, zero when empty
//   count, full   - occupancy and full flag
module fetch_iq
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enq,
   input  iq_entry_t                enq_data,
   input  logic                     deq,
   input  logic                     flush,
   output iq_entry_t                head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   iq_entry_t mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic do_enq, do_deq;
   assign full   = count == (AW+1)'(DEPTH);
   assign do_enq = enq && !full && !flush;
   assign do_deq = deq && count != '0 && !flush;
   assign head   = count != '0 ? mem[rd] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         wr    <= wr + AW'(do_enq);
         rd    <= rd + AW'(do_deq);
         count <= count + (AW+1)'(do_enq) - (AW+1)'(do_deq);
      end
   end
   always_ff @(posedge clk)
      if (do_enq) mem[wr] <= enq_data;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + single-outstanding fetch FSM feeding an instruction queue.
//   clk, rst                   - clock, asynchronous active-high reset
//   redirect_valid/_pc         - flush and restart fetch at redirect_pc (word aligned)
//   sb_req_valid/_addr/_ready  - demand fetch request to the stream buffer
//   sb_resp_valid/_data        - one-cycle response pulse from the stream buffer
//   sb_invalidate              - stream buffer flush, high during a redirect
//   iq_valid/_inst/_pc, iq_deq - instruction queue head towards decode
//   perf_fetched/_dropped      - saturating response counters, only with FETCH_PERF_EN
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int          IQ_DEPTH = 8,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        sb_req_valid,
   output logic [31:0] sb_req_addr,
   input  logic        sb_req_ready,
   input  logic        sb_resp_valid,
   input  logic [31:0] sb_resp_data,
   output logic        sb_invalidate,
   output logic        iq_valid,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   input  logic        iq_deq
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);
   fetch_state_t state, state_n;
   logic [31:0] pc, req_pc;
   logic accept, keep, full;
   logic [$clog2(IQ_DEPTH):0] count;
   iq_entry_t head;
   // Issuing only from IDLE with a free slot guarantees room for the response.
   assign sb_req_valid  = !rst && state == IDLE && !redirect_valid && !full;
   assign sb_req_addr   = pc;
   assign sb_invalidate = !rst && redirect_valid;
   assign accept        = sb_req_valid && sb_req_ready;
   assign keep          = state == WAIT && sb_resp_valid && !redirect_valid;
   // Any response retires the outstanding request; a redirect without one turns it stale.
   always_comb
      state_n = state == IDLE ? (accept ? WAIT : IDLE) :
                sb_resp_valid ? IDLE :
                state == WAIT && !redirect_valid ? WAIT : DROP;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         state  <= state_n;
         pc     <= redirect_valid ? redirect_pc & 32'hffff_fffc : accept ? pc + 32'd4 : pc;
         if (accept) req_pc <= pc;
      end
   end
   fetch_iq #(.DEPTH(IQ_DEPTH)) u_iq (
      .clk      (clk),
      .rst      (rst),
      .enq      (keep),
      .enq_data ('{pc: req_pc, inst: sb_resp_data}),
      .deq      (iq_deq),
      .flush    (redirect_valid),
      .head     (head),
      .count    (count),
      .full     (full)
   );
   assign iq_valid = count != '0;
   assign iq_pc    = head.pc;
   assign iq_inst  = head.inst;
`ifdef FETCH_PERF_EN
   logic drop;
   assign drop = sb_resp_valid && (state == DROP || (state == WAIT && redirect_valid));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         if (keep && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
         if (drop && perf_dropped != '1) perf_dropped <= perf_dropped + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed bench for fetch_stage against a queue-based model.
module tb_fetch_stage;
   import fetch_pkg::*;
   logic clk = 0, rst = 1, redirect_valid = 0, sb_req_ready = 0, sb_resp_valid = 0, iq_deq = 0;
   logic [31:0] redirect_pc = 0, sb_resp_data = 0;
   logic sb_req_valid, sb_invalidate, iq_valid;
   logic [31:0] sb_req_addr, iq_inst, iq_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_dropped;
`endif
   fetch_stage dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .sb_req_valid(sb_req_valid), .sb_req_addr(sb_req_addr), .sb_req_ready(sb_req_ready),
      .sb_resp_valid(sb_resp_valid), .sb_resp_data(sb_resp_data), .sb_invalidate(sb_invalidate),
      .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_deq(iq_deq)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
   );
   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   // model: architectural PC, one outstanding request (maybe stale), queue of expected entries
   logic [31:0] m_pc, m_req;
   bit m_out, m_stale;
   logic [31:0] q_pc[$], q_inst[$];
   int unsigned m_fetched, m_dropped;
   // stream buffer responder
   bit sb_pend, spur_en;
   int sb_cnt;
   logic [31:0] sb_addr;
   // outputs sampled in the last step
   logic s_rv, s_inv, s_iqv;
   logic [31:0] s_addr, s_iqpc, s_iqinst;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1; redirect_valid = 1; sb_resp_valid = 0; iq_deq = 0; sb_req_ready = 1;
      #1;
      chk("rst_req_valid", sb_req_valid, 0);
      chk("rst_invalidate", sb_invalidate, 0);
      chk("rst_iq_valid", iq_valid, 0);
      chk("rst_iq_pc", iq_pc, 0);
      chk("rst_iq_inst", iq_inst, 0);
      m_pc = RESET_PC_DEFAULT; m_out = 0; m_stale = 0; m_fetched = 0; m_dropped = 0;
      q_pc.delete(); q_inst.delete(); sb_pend = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      redirect_valid = 0; sb_req_ready = 0; rst = 0;
      #1;
      chk("first_req_valid", sb_req_valid, 1);
      chk("first_req_addr", sb_req_addr, RESET_PC_DEFAULT);
   endtask

   task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy, input logic dq, input int lat);
      logic resp, ev;
      logic [31:0] rdata;
      @(negedge clk);
      resp = 0; rdata = 0;
      if (sb_pend) begin
         if (sb_cnt == 0) begin resp = 1; rdata = sb_addr ^ 32'hffffffff; end
         else sb_cnt--;
      end else if (spur_en && !m_out && $urandom % 8 == 0) begin
         resp = 1; rdata = $urandom;
      end
      redirect_valid = rv; redirect_pc = rpc; sb_req_ready = rdy; iq_deq = dq;
      sb_resp_valid = resp; sb_resp_data = rdata;
      #1;
      ev = !m_out && !rv && q_pc.size() < 8;
      s_rv = sb_req_valid; s_addr = sb_req_addr; s_inv = sb_invalidate;
      s_iqv = iq_valid; s_iqpc = iq_pc; s_iqinst = iq_inst;
      chk("req_valid", sb_req_valid, ev);
      chk("req_addr", sb_req_addr, m_pc);
      chk("invalidate", sb_invalidate, rv);
      chk("iq_valid", iq_valid, q_pc.size() != 0);
      if (q_pc.size() != 0) begin
         chk("iq_pc", iq_pc, q_pc[0]);
         chk("iq_inst", iq_inst, q_inst[0]);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_dropped", perf_dropped, m_dropped);
`endif
      @(posedge clk);
      if (resp) sb_pend = 0;
      if (s_rv && rdy) begin sb_pend = 1; sb_cnt = lat; sb_addr = s_addr; end
      if (rv) begin
         m_pc = {rpc[31:2], 2'b00};
         q_pc.delete(); q_inst.delete();
         if (m_out && resp) begin m_out = 0; m_dropped++; end
         else if (m_out) m_stale = 1;
      end else begin
         if (dq && q_pc.size() != 0) begin void'(q_pc.pop_front()); void'(q_inst.pop_front()); end
         if (m_out && resp) begin
            if (m_stale) m_dropped++;
            else begin q_pc.push_back(m_req); q_inst.push_back(rdata); m_fetched++; end
            m_out = 0;
         end
         if (ev && rdy) begin m_out = 1; m_stale = 0; m_req = m_pc; m_pc = m_pc + 32'd4; end
      end
   endtask

   initial begin
      int issued;
      spur_en = 0;
      do_reset();
      // back-to-back hits with decode always popping
      step(0, 0, 1, 1, 0);
      chk("a_c0_valid", s_rv, 1);
      chk("a_c0_addr", s_addr, 32'h1eceb000);
      step(0, 0, 1, 1, 0);
      chk("a_c1_valid", s_rv, 0);
      step(0, 0, 1, 1, 0);
      chk("a_c2_addr", s_addr, 32'h1eceb004);
      chk("a_c2_iq_pc", s_iqpc, 32'h1eceb000);
      chk("a_c2_iq_inst", s_iqinst, 32'he1314fff);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      chk("a_c4_addr", s_addr, 32'h1eceb008);
      chk("a_c4_iq_pc", s_iqpc, 32'h1eceb004);
      // fill the queue with decode stalled
      do_reset();
      issued = 0;
      repeat (20) begin step(0, 0, 1, 0, 0); issued += int'(s_rv); end
      chk("b_fill_issued", issued, 8);
      step(0, 0, 1, 1, 0);
      issued = int'(s_rv);
      repeat (10) begin step(0, 0, 1, 0, 0); issued += int'(s_rv); end
      chk("b_one_more", issued, 1);
      // redirect while a request is outstanding
      do_reset();
      step(0, 0, 1, 1, 2);
      chk("c_accept", s_rv, 1);
      step(1, 32'h00001003, 1, 1, 0);
      chk("c_inv_on", s_inv, 1);
      chk("c_no_issue", s_rv, 0);
      step(0, 0, 1, 1, 0);
      chk("c_inv_off", s_inv, 0);
      step(0, 0, 1, 1, 0);
      chk("c_drop_iqv", s_iqv, 0);
      step(0, 0, 1, 1, 0);
      chk("c_new_valid", s_rv, 1);
      chk("c_new_addr", s_addr, 32'h00001000);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      chk("c_iq_pc", s_iqpc, 32'h00001000);
      chk("c_iq_inst", s_iqinst, 32'hffffefff);
      // redirect coinciding with the response, then ready stalls
      do_reset();
      step(0, 0, 1, 0, 0);
      step(1, 32'h00000040, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("d_valid", s_rv, 1);
      chk("d_addr", s_addr, 32'h00000040);
      chk("d_iqv", s_iqv, 0);
      repeat (4) begin
         step(0, 0, 0, 0, 0);
         chk("e_hold_valid", s_rv, 1);
         chk("e_hold_addr", s_addr, 32'h00000040);
      end
      step(0, 0, 1, 0, 0);
      chk("e_accept_addr", s_addr, 32'h00000040);
      step(0, 0, 1, 0, 0);
      chk("e_wait", s_rv, 0);
      // randomized traffic with redirects, wrap-around targets, spurious responses, resets
      spur_en = 1;
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] rpc;
         if (i % 800 == 799) do_reset();
         rpc = ($urandom % 4 == 0) ? (32'hfffffff0 | ($urandom % 16)) : $urandom;
         step($urandom % 16 == 0, rpc, $urandom % 4 != 0,
              ((i / 400) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 3 != 0),
              $urandom_range(0, 3));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
